// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake and bus signal of the ALU arbiter:
//   req0_* / req1_*  : requester valid/ready handshakes with 69-bit operation
//                      words {sel[3:0], cin, a[31:0], b[31:0]}
//   alu_*            : operand drive to, and result/flags from, the shared ALU
//   rsp_*            : held response toward the consumer (valid/ready)
//   ops_done         : count of completed responses (CNT_W bits)
// Modports:
//   slave  - the arbiter side
//   master - the environment side (requesters, ALU, consumer)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic [68:0]      req0_op;
  logic             req0_ready;
  logic             req1_valid;
  logic [68:0]      req1_op;
  logic             req1_ready;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_sel;
  logic             alu_cin;
  logic [31:0]      alu_y;
  logic [3:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_y;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic [CNT_W-1:0] ops_done;

  modport slave (
    input  req0_valid, req0_op, req1_valid, req1_op, alu_y, alu_flags, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_sel, alu_cin,
    output rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, ops_done
  );

  modport master (
    output req0_valid, req0_op, req1_valid, req1_op, alu_y, alu_flags, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_sel, alu_cin,
    input  rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, ops_done
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Arbitrates two requesters onto one shared combinational 32-bit ALU.
// Flow: IDLE (grant + latch operation) -> EXEC (capture ALU result) ->
// RESP (hold response until consumer accepts) -> IDLE.
// Accept at cycle T gives rsp_valid at T+2; back-to-back issue every 3 cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - alu_arbiter_if.slave: requester handshakes, ALU drive/return,
//          response handshake and completed-operation counter
// Parameters:
//   RR    - 1: round-robin on contention, 0: requester 0 always wins
//   CNT_W - width of ops_done
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter bit RR    = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [68:0]      op_q, op_d;
  logic [31:0]      rsp_y_q, rsp_y_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  // Requester that wins the next tie; reset value 0 so requester 0 wins first.
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic             grant0_s, grant1_s;

  // sel codes 1001, 1110 and 1111 have no ALU function.
  function automatic logic sel_unsupported(input logic [3:0] sel);
    logic res;
    case (sel)
      4'b1001, 4'b1110, 4'b1111: res = 1'b1;
      default:                   res = 1'b0;
    endcase
    return res;
  endfunction

  // Grant decision: only in IDLE and never while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if ((RR == 1'b1) && prio_q) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
      end else if (bus.req0_valid) begin
        grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    prio_d      = prio_q;
    ops_done_d  = ops_done_q;
    case (state_q)
      IDLE: begin
        if (grant0_s) begin
          op_d     = bus.req0_op;
          rsp_id_d = 1'b0;
          state_d  = EXEC;
        end else if (grant1_s) begin
          op_d     = bus.req1_op;
          rsp_id_d = 1'b1;
          state_d  = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // Unsupported codes return an all-zero result so the consumer never
        // sees whatever the ALU happens to produce for them.
        if (sel_unsupported(op_q[68:65])) begin
          rsp_y_d     = 32'h0000_0000;
          rsp_flags_d = 4'b0000;
          rsp_err_d   = 1'b1;
        end else begin
          rsp_y_d     = bus.alu_y;
          rsp_flags_d = bus.alu_flags;
          rsp_err_d   = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          // The owner of this response loses the next tie.
          prio_d     = ~rsp_id_q;
          ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d    = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 69'd0;
      rsp_y_q     <= 32'h0000_0000;
      rsp_flags_q <= 4'b0000;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      prio_q      <= 1'b0;
      ops_done_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      prio_q      <= prio_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;
  assign bus.alu_sel    = op_q[68:65];
  assign bus.alu_cin    = op_q[64];
  assign bus.alu_a      = op_q[63:32];
  assign bus.alu_b      = op_q[31:0];
  // Masked by rst so a consumer never sees a handshake on a dropped operation.
  assign bus.rsp_valid  = (state_q == RESP) && !rst;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench: dut_a uses round-robin, dut_b fixed priority. A small ALU
// model closes the alu_* loop on each bus. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_ops_a;

  alu_arbiter_if #(.CNT_W(16)) bus_a ();
  alu_arbiter_if #(.CNT_W(16)) bus_b ();

  alu_arbiter #(.RR(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  alu_arbiter #(.RR(1'b0), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // Reference ALU: returns {flags, y}, flags = {Cout, N, Z, V(=0)}.
  function automatic logic [35:0] alu_model(input logic [3:0] sel, input logic cin,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    case (sel)
      4'b0000: r = {1'b0, a & b};
      4'b0110: r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      4'b0111: r = {1'b0, a} - {1'b0, b};
      4'b1000: r = {1'b0, a | b};
      4'b1010: r = {1'b0, ~a};
      default: r = {1'b0, a ^ b};
    endcase
    return {r[32], r[31], (r[31:0] == 32'd0), 1'b0, r[31:0]};
  endfunction

  assign {bus_a.alu_flags, bus_a.alu_y} = alu_model(bus_a.alu_sel, bus_a.alu_cin, bus_a.alu_a, bus_a.alu_b);
  assign {bus_b.alu_flags, bus_b.alu_y} = alu_model(bus_b.alu_sel, bus_b.alu_cin, bus_b.alu_a, bus_b.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // One lone-requester operation on dut_a with rsp_ready held high.
  task automatic run_single_a(input logic id, input logic [68:0] op, input logic [31:0] ey,
                              input logic [3:0] ef, input logic eerr);
    step();
    if (id) begin
      bus_a.req1_valid = 1'b1;
      bus_a.req1_op    = op;
    end else begin
      bus_a.req0_valid = 1'b1;
      bus_a.req0_op    = op;
    end
    mid();
    check_eq("single_rdy0", bus_a.req0_ready, !id);
    check_eq("single_rdy1", bus_a.req1_ready, id);
    step();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    mid();
    check_eq("single_exec_valid", bus_a.rsp_valid, 1'b0);
    step();
    mid();
    check_eq("single_rsp_valid", bus_a.rsp_valid, 1'b1);
    check_eq("single_rsp_y", bus_a.rsp_y, ey);
    check_eq("single_rsp_flags", bus_a.rsp_flags, ef);
    check_eq("single_rsp_err", bus_a.rsp_err, eerr);
    check_eq("single_rsp_id", bus_a.rsp_id, id);
    step();
    mid();
    exp_ops_a++;
    check_eq("single_ops_done", bus_a.ops_done, exp_ops_a);
  endtask

  initial begin
    int n_acc;
    int n_rsp;
    int last_acc;
    n_checks  = 0;
    n_errors  = 0;
    exp_ops_a = 0;
    rst = 1'b1;
    bus_a.req0_valid = 1'b0; bus_a.req0_op = 69'd0;
    bus_a.req1_valid = 1'b0; bus_a.req1_op = 69'd0;
    bus_a.rsp_ready  = 1'b1;
    bus_b.req0_valid = 1'b0; bus_b.req0_op = 69'd0;
    bus_b.req1_valid = 1'b0; bus_b.req1_op = 69'd0;
    bus_b.rsp_ready  = 1'b1;

    // Reset: no grant while rst is high even with a valid request.
    step();
    bus_a.req0_valid = 1'b1;
    bus_a.req0_op    = {4'b0110, 1'b0, 32'd5, 32'd3};
    mid();
    check_eq("rst_ready0", bus_a.req0_ready, 1'b0);
    check_eq("rst_rsp_valid", bus_a.rsp_valid, 1'b0);
    step();
    mid();
    check_eq("rst_ops_done", bus_a.ops_done, 16'd0);
    check_eq("rst_rsp_y", bus_a.rsp_y, 32'd0);
    check_eq("rst_alu_a", bus_a.alu_a, 32'd0);
    check_eq("rst_b_ops_done", bus_b.ops_done, 16'd0);

    // Single op 5+3: grant in first cycle after reset, response at T+2.
    step();
    rst = 1'b0;
    mid();
    check_eq("t1_ready0", bus_a.req0_ready, 1'b1);
    check_eq("t1_ready1", bus_a.req1_ready, 1'b0);
    step();
    bus_a.req0_valid = 1'b0;
    mid();
    check_eq("t1_exec_valid", bus_a.rsp_valid, 1'b0);
    check_eq("t1_alu_a", bus_a.alu_a, 32'd5);
    check_eq("t1_ready0_exec", bus_a.req0_ready, 1'b0);
    step();
    mid();
    check_eq("t1_rsp_valid", bus_a.rsp_valid, 1'b1);
    check_eq("t1_rsp_y", bus_a.rsp_y, 32'd8);
    check_eq("t1_rsp_id", bus_a.rsp_id, 1'b0);
    check_eq("t1_rsp_err", bus_a.rsp_err, 1'b0);
    check_eq("t1_ops_before", bus_a.ops_done, 16'd0);
    step();
    mid();
    exp_ops_a = 1;
    check_eq("t1_ops_done", bus_a.ops_done, 16'd1);
    check_eq("t1_idle_valid", bus_a.rsp_valid, 1'b0);

    // Supported/unsupported sel boundaries and carry out.
    run_single_a(1'b0, {4'b1010, 1'b0, 32'h0000_0000, 32'h0000_0000}, 32'hFFFF_FFFF, 4'b0100, 1'b0);
    run_single_a(1'b1, {4'b1000, 1'b0, 32'h0000_0000, 32'h0000_0000}, 32'h0000_0000, 4'b0010, 1'b0);
    run_single_a(1'b1, {4'b1001, 1'b0, 32'd7, 32'd9}, 32'h0000_0000, 4'b0000, 1'b1);
    run_single_a(1'b0, {4'b1111, 1'b0, 32'd1, 32'd1}, 32'h0000_0000, 4'b0000, 1'b1);
    run_single_a(1'b0, {4'b0110, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000}, 32'h0000_0000, 4'b1010, 1'b0);

    // Round-robin contention after a fresh reset: ids 0,1,0,1 three cycles apart.
    step();
    rst = 1'b1;
    mid();
    step();
    rst = 1'b0;
    bus_a.req0_valid = 1'b1; bus_a.req0_op = {4'b0110, 1'b0, 32'd10, 32'd20};
    bus_a.req1_valid = 1'b1; bus_a.req1_op = {4'b0110, 1'b1, 32'd100, 32'd1};
    n_acc = 0; n_rsp = 0; last_acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      mid();
      if (bus_a.req0_ready || bus_a.req1_ready) begin
        check_eq("rr_gnt_id", bus_a.req1_ready, n_acc % 2);
        check_eq("rr_both", bus_a.req0_ready & bus_a.req1_ready, 1'b0);
        if (n_acc > 0) check_eq("rr_gap", cyc - last_acc, 3);
        last_acc = cyc;
        n_acc++;
      end
      if (bus_a.rsp_valid) begin
        check_eq("rr_rsp_id", bus_a.rsp_id, n_rsp % 2);
        check_eq("rr_rsp_y", bus_a.rsp_y, ((n_rsp % 2) == 1) ? 32'd102 : 32'd30);
        n_rsp++;
      end
      if (cyc < 11) step();
    end
    step();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    mid();
    check_eq("rr_n_acc", n_acc, 4);
    check_eq("rr_n_rsp", n_rsp, 4);
    check_eq("rr_ops_done", bus_a.ops_done, 16'd4);

    // Backpressure: 5 cycles of rsp_ready=0 while req0 waits.
    step();
    bus_a.rsp_ready  = 1'b0;
    bus_a.req1_valid = 1'b1;
    bus_a.req1_op    = {4'b0000, 1'b0, 32'h0000_F0F0, 32'h0000_FF00};
    mid();
    check_eq("bp_ready1", bus_a.req1_ready, 1'b1);
    check_eq("bp_ready0", bus_a.req0_ready, 1'b0);
    step();
    bus_a.req1_valid = 1'b0;
    bus_a.req0_valid = 1'b1;
    mid();
    check_eq("bp_exec_ready0", bus_a.req0_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      mid();
      check_eq("bp_hold_valid", bus_a.rsp_valid, 1'b1);
      check_eq("bp_hold_y", bus_a.rsp_y, 32'h0000_F000);
      check_eq("bp_hold_flags", bus_a.rsp_flags, 4'b0000);
      check_eq("bp_hold_id", bus_a.rsp_id, 1'b1);
      check_eq("bp_hold_ops", bus_a.ops_done, 16'd4);
      check_eq("bp_hold_ready0", bus_a.req0_ready, 1'b0);
    end
    step();
    bus_a.rsp_ready  = 1'b1;
    bus_a.req0_valid = 1'b0;
    mid();
    check_eq("bp_hs_valid", bus_a.rsp_valid, 1'b1);
    check_eq("bp_hs_ops", bus_a.ops_done, 16'd4);
    step();
    mid();
    check_eq("bp_ops_done", bus_a.ops_done, 16'd5);
    check_eq("bp_idle_valid", bus_a.rsp_valid, 1'b0);

    // Reset in EXEC drops the op; next contention goes to requester 0.
    step();
    bus_a.req1_valid = 1'b1;
    bus_a.req1_op    = {4'b0110, 1'b0, 32'd1, 32'd2};
    mid();
    check_eq("rm_ready1", bus_a.req1_ready, 1'b1);
    step();
    bus_a.req1_valid = 1'b0;
    rst = 1'b1;
    mid();
    check_eq("rm_rst_valid", bus_a.rsp_valid, 1'b0);
    step();
    rst = 1'b0;
    bus_a.req0_valid = 1'b1;
    bus_a.req1_valid = 1'b1;
    mid();
    check_eq("rm_valid", bus_a.rsp_valid, 1'b0);
    check_eq("rm_ops_done", bus_a.ops_done, 16'd0);
    check_eq("rm_rsp_y", bus_a.rsp_y, 32'd0);
    check_eq("rm_rsp_id", bus_a.rsp_id, 1'b0);
    check_eq("rm_ready0", bus_a.req0_ready, 1'b1);
    check_eq("rm_ready1_tie", bus_a.req1_ready, 1'b0);
    step();
    bus_a.req0_valid = 1'b0;
    bus_a.req1_valid = 1'b0;
    mid();
    step();
    mid();
    check_eq("rm_rsp_valid", bus_a.rsp_valid, 1'b1);
    check_eq("rm_rsp_id2", bus_a.rsp_id, 1'b0);
    check_eq("rm_rsp_y2", bus_a.rsp_y, 32'd30);
    step();
    mid();
    check_eq("rm_ops_after", bus_a.ops_done, 16'd1);

    // Fixed priority: requester 0 always wins, requester 1 never ready.
    step();
    bus_b.req0_valid = 1'b1; bus_b.req0_op = {4'b0110, 1'b0, 32'd1, 32'd1};
    bus_b.req1_valid = 1'b1; bus_b.req1_op = {4'b0110, 1'b0, 32'd3, 32'd3};
    n_acc = 0;
    n_rsp = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      mid();
      check_eq("fp_ready1", bus_b.req1_ready, 1'b0);
      if (bus_b.req0_ready) n_acc++;
      if (bus_b.rsp_valid) begin
        check_eq("fp_rsp_id", bus_b.rsp_id, 1'b0);
        check_eq("fp_rsp_y", bus_b.rsp_y, 32'd2);
        n_rsp++;
      end
      if (cyc < 8) step();
    end
    step();
    bus_b.req0_valid = 1'b0;
    bus_b.req1_valid = 1'b0;
    mid();
    check_eq("fp_n_acc", n_acc, 3);
    check_eq("fp_n_rsp", n_rsp, 3);
    check_eq("fp_ops_done", bus_b.ops_done, 16'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
